// File: rtl/berger_scrub_controller.sv
// Background scrubber for a Berger-protected memory: sweeps every address, counts detected errors
// and logs failing {addr,data} pairs into a show-ahead FIFO drained by the host.
module berger_scrub_controller #(
    parameter int unsigned ADDR_W    = 4,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned RD_LAT    = 1,
    parameter int unsigned LOG_DEPTH = 4,
    parameter int unsigned CNT_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              hold,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              mem_error,
    output logic [CNT_W-1:0]  err_count,
    output logic              log_valid,
    output logic [ADDR_W-1:0] log_addr,
    output logic [DATA_W-1:0] log_data,
    input  logic              log_ready,
    output logic              log_overflow
);

    localparam int unsigned LW = $clog2(LOG_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t                   r_state;
    logic                     r_busy;
    logic                     r_done;
    logic [ADDR_W-1:0]        r_addr;
    logic [2:0]               r_drain;
    logic [RD_LAT-1:0]        r_pv;
    logic [ADDR_W-1:0]        r_pa [RD_LAT];
    logic [CNT_W-1:0]         r_cnt;
    logic                     r_ovf;
    logic [ADDR_W+DATA_W-1:0] r_mem [LOG_DEPTH];
    logic [LW:0]              r_wp;
    logic [LW:0]              r_rp;

    logic                     w_start;
    logic                     w_rd_en;
    logic                     w_err;
    logic                     w_empty;
    logic                     w_full;
    logic                     w_pop;
    logic                     w_push;
    logic [ADDR_W+DATA_W-1:0] w_head;

    assign w_start = (r_state == S_IDLE) && start;
    // Read enable follows hold in the same cycle so the write port can be granted immediately.
    assign w_rd_en = (r_state == S_ISSUE) && !hold;
    assign w_err   = r_pv[RD_LAT-1] && mem_error;
    assign w_empty = (r_wp == r_rp);
    assign w_full  = (r_wp[LW] != r_rp[LW]) && (r_wp[LW-1:0] == r_rp[LW-1:0]);
    assign w_pop   = !w_empty && log_ready;
    assign w_push  = w_err && (!w_full || w_pop);
    assign w_head  = w_empty ? '0 : r_mem[r_rp[LW-1:0]];

    assign busy         = r_busy;
    assign done         = r_done;
    assign mem_rd_en    = w_rd_en;
    assign mem_addr     = r_addr;
    assign err_count    = r_cnt;
    assign log_overflow = r_ovf;
    assign log_valid    = !w_empty;
    assign log_addr     = w_head[ADDR_W+DATA_W-1:DATA_W];
    assign log_data     = w_head[DATA_W-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_addr  <= '0;
            r_drain <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_ISSUE;
                        r_busy  <= 1'b1;
                        r_addr  <= '0;
                    end
                end
                S_ISSUE: begin
                    if (!hold) begin
                        if (r_addr == '1) begin
                            r_state <= S_DRAIN;
                            r_drain <= '0;
                        end else begin
                            r_addr <= r_addr + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (r_drain == 3'(RD_LAT - 1)) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_drain <= r_drain + 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Response tracker: mirrors the memory read latency so data is sampled in its valid cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pv <= '0;
            for (int unsigned i = 0; i < RD_LAT; i++) r_pa[i] <= '0;
        end else begin
            r_pv[0] <= w_rd_en;
            r_pa[0] <= r_addr;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pa[i] <= r_pa[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
            r_ovf <= 1'b0;
            r_wp  <= '0;
            r_rp  <= '0;
        end else begin
            if (w_start) begin
                r_cnt <= '0;
                r_ovf <= 1'b0;
            end else if (w_err) begin
                if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
                if (!w_push) r_ovf <= 1'b1;
            end
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop)  r_rp <= r_rp + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp[LW-1:0]] <= {r_pa[RD_LAT-1], mem_data};
    end

endmodule
